// File: rtl/seven_segment_scan_driver_pkg.sv
// Shared types, glyph table and glyph lookup for the seven-segment scan driver.
package seven_segment_pkg;

  typedef logic [6:0] seg_t;

  // Glyphs encoded {a,b,c,d,e,f,g}, index 0 is code 0 (rightmost element).
  localparam seg_t [15:0] GLYPH_TBL = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  // Decimal-mode glyph for codes 10..15: segment g only.
  localparam seg_t ERR_GLYPH = 7'h01;

  function automatic seg_t glyph(input logic [3:0] code, input logic hex_mode);
    if (!hex_mode && (code > 4'd9)) return ERR_GLYPH;
    return GLYPH_TBL[code];
  endfunction

endpackage

// File: rtl/seven_segment_scan_driver_if.sv
// Datapath-facing and pin-facing signals of the scan driver.
interface seven_segment_scan_driver_if #(parameter int NUM_DIGITS = 4);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;
  logic                    pending;

  modport master (output en, load, value, dp_in,
                  input  seg, dp, an, frame_start, pending);
  modport slave  (input  en, load, value, dp_in,
                  output seg, dp, an, frame_start, pending);
endinterface

// File: rtl/seven_segment_scan_timer.sv
// Refresh divider: counts SCAN_DIV cycles per digit, tc on the last one.
module seven_segment_scan_timer #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tc
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0] div;

  assign tc = en && (div == DIV_W'(SCAN_DIV - 1));

  // Divider wraps on tc, freezes while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     div <= '0;
    else if (tc) div <= '0;
    else if (en) div <= div + 1'b1;
  end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed seven-segment driver with frame-aligned double buffering.
// Optional: define SEVEN_SEGMENT_SCAN_LEADING_ZERO_BLANK_EN for leading zero blanking.
import seven_segment_pkg::*;

module seven_segment_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int HEX_MODE   = 1
) (
  input  logic clk,
  input  logic rst,
  seven_segment_scan_driver_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic                    tc, wrap;
  logic [IDX_W-1:0]        idx, idx_nxt, sel_idx;
  logic [4*NUM_DIGITS-1:0] pend_val, act_val, disp_val;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp, disp_dp;
  logic                    pending_q;
  logic                    en_q;
  logic [NUM_DIGITS-1:0]   blank;
  logic [3:0]              sel_code;
  seg_t                    sel_seg;
  logic                    sel_dp;
  logic [NUM_DIGITS-1:0]   sel_an;
  seg_t                    seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic                    frame_q;

  seven_segment_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk (clk),
    .rst (rst),
    .en  (bus.en),
    .tc  (tc)
  );

  // Next digit, frame wrap, and the data the output registers will load.
  // On a wrap the just-committed buffer is bypassed in so digit 0 is fresh.
  always_comb begin
    idx_nxt  = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    wrap     = tc && (idx == LAST_IDX);
    disp_val = (wrap && pending_q) ? pend_val : act_val;
    disp_dp  = (wrap && pending_q) ? pend_dp  : act_dp;
    sel_idx  = tc ? idx_nxt : idx;
    sel_code = disp_val[4*int'(sel_idx) +: 4];
    sel_seg  = blank[sel_idx] ? seg_t'(0) : glyph(sel_code, HEX_MODE != 0);
    sel_dp   = disp_dp[sel_idx];
    sel_an   = NUM_DIGITS'(1) << sel_idx;
  end

`ifdef SEVEN_SEGMENT_SCAN_LEADING_ZERO_BLANK_EN
  logic lz_seen;

  // Blank zero codes from the top digit down to the first nonzero one; digit 0 always shows.
  always_comb begin
    blank   = '0;
    lz_seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (disp_val[4*k +: 4] != 4'd0) lz_seen = 1'b1;
      blank[k] = ~lz_seen;
    end
  end
`else
  // No blanking: every digit shows its glyph.
  always_comb begin
    blank = '0;
  end
`endif

  // Digit index advances on each tc; reset parks it on the last digit so the first tc wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     idx <= LAST_IDX;
    else if (tc) idx <= idx_nxt;
  end

  // Double buffer: commit on wrap, then a same-edge load overrides pending so it stays set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_val  <= '0;
      pend_dp   <= '0;
      act_val   <= '0;
      act_dp    <= '0;
      pending_q <= 1'b0;
    end else begin
      if (wrap && pending_q) begin
        act_val   <= pend_val;
        act_dp    <= pend_dp;
        pending_q <= 1'b0;
      end
      if (bus.load) begin
        pend_val  <= bus.value;
        pend_dp   <= bus.dp_in;
        pending_q <= 1'b1;
      end
    end
  end

  // Output registers: dark while disabled, reload on tc or on the first enabled edge after a freeze.
  // en_q resets high so the display stays dark until the first tc after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= 1'b1;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      an_q    <= '0;
      frame_q <= 1'b0;
    end else begin
      en_q    <= bus.en;
      frame_q <= wrap;
      if (!bus.en) begin
        seg_q <= '0;
        dp_q  <= 1'b0;
        an_q  <= '0;
      end else if (tc || !en_q) begin
        seg_q <= sel_seg;
        dp_q  <= sel_dp;
        an_q  <= sel_an;
      end
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_q;
  assign bus.pending     = pending_q;

endmodule
